// File: rtl/alu_writeback_if.sv
// alu_writeback_if: valid/ready result channel from the ALU into the writeback stage
interface alu_writeback_if #(
  parameter int word_size = 32,
  parameter int reg_addr = 4
);
  logic res_valid;
  logic res_ready;
  logic [2*word_size-1:0] res_data;
  logic [4:0] res_opcode;
  logic [reg_addr-1:0] res_rd;
  modport master (output res_valid, res_data, res_opcode, res_rd, input res_ready);
  modport slave (input res_valid, res_data, res_opcode, res_rd, output res_ready);
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback: retires ALU results as a register-file write or a LO-then-HI update
module alu_writeback #(
  parameter int word_size = 32,
  parameter int reg_addr = 4
) (
  input  logic clk,
  input  logic clr,
  alu_writeback_if.slave res,
  output logic wr_en,
  output logic [reg_addr-1:0] wr_addr,
  output logic [word_size-1:0] wr_data,
  output logic [word_size-1:0] lo_out,
  output logic [word_size-1:0] hi_out,
  output logic done,
  output logic illegal
);
  typedef enum logic [2:0] {IDLE, RD, LO, HI, ERR} state_t;
  state_t state, state_nx;
  logic [word_size-1:0] z_lo, z_hi;
  logic accept, is_long, is_bad;
  assign res.res_ready = clr && state != LO;
  assign accept = res.res_valid && res.res_ready;
  assign is_long = res.res_opcode == 5'd3 || res.res_opcode == 5'd4;
  assign is_bad = res.res_opcode == 5'd0 || res.res_opcode[4];
  // next state: a new accept always wins; LO always advances to HI
  always_comb begin
    state_nx = accept ? (is_bad ? ERR : is_long ? LO : RD) : (state == LO ? HI : IDLE);
    done = state == RD || state == HI || state == ERR;
    illegal = state == ERR;
  end
  // state, captured result, HI/LO and the held register-file write port
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      z_lo <= '0;
      z_hi <= '0;
      lo_out <= '0;
      hi_out <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        z_lo <= res.res_data[word_size-1:0];
        z_hi <= res.res_data[2*word_size-1:word_size];
      end
      if (state == LO) lo_out <= z_lo;
      if (state == HI) hi_out <= z_hi;
      wr_en <= accept && !is_bad && !is_long && res.res_rd != '0;
      if (accept && !is_bad && !is_long && res.res_rd != '0) begin
        wr_addr <= res.res_rd;
        wr_data <= res.res_data[word_size-1:0];
      end
    end
  end
endmodule

// File: doc/alu_writeback.md
# alu_writeback

Result-retirement stage directly downstream of the 64-bit ALU. Accepts the ALU's 64-bit result C plus its opcode and destination register over a valid/ready handshake. Retires it as one register-file write (single-word ops) or as a two-cycle LO-then-HI update (mul/div), and flags illegal opcodes. Sits between the ALU output and the register file / HI-LO pair.

## Interface
- wordSize, 32, datapath word width; result input is 2*wordSize.
- regAddr, 4, register-file address width.

- clk  input  1  sole clock; all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-low.
- res_valid  input  1  result presented this cycle.
- res_ready  output  1  stage will accept this cycle.
- res_data  input  2*wordSize  ALU result C.
- res_opcode  input  5  opcode that produced res_data.
- res_rd  input  regAddr  destination register index.
- wr_en  output  1  register-file write strobe.
- wr_addr  output  regAddr  register-file write address.
- wr_data  output  wordSize  register-file write data.
- lo_out  output  wordSize  LO register.
- hi_out  output  wordSize  HI register.
- done  output  1  one-cycle pulse in the final cycle of each transaction.
- illegal  output  1  one-cycle pulse for an illegal opcode.

## Operation
- Opcode classes:
  - mul = 5'b00011 and div = 5'b00100 are LONG.
  - 5'b00001–5'b01111 other than these are SHORT.
  - 5'b00000 and 5'b10000–5'b11111 are ILLEGAL.
- Accept: res_valid && res_ready at a rising edge. This captures ZLo = res_data[31:0], ZHi = res_data[63:32], opcode and rd into internal registers.
- States: IDLE, RD, LO, HI, ERR. Transitions occur at an accepting edge:
  - SHORT → RD
  - LONG → LO
  - ILLEGAL → ERR
- Without an accept: IDLE, RD and ERR → IDLE; HI → IDLE; LO → HI unconditionally.
- RD:
  - wr_en = (rd != 0); register 0 is never written.
  - wr_addr = rd, wr_data = ZLo, done = 1.
- LO: lo_out <= ZLo at end of cycle; no register-file write.
- HI: hi_out <= ZHi at end of cycle; done = 1.
- ERR: illegal = 1, done = 1; no writes; captured data discarded.
- res_ready = clr && state ∈ {IDLE, RD, HI, ERR}. It is low only in LO, i.e. ready is high in every final cycle, allowing back-to-back accepts.
- wr_en, wr_addr, wr_data, done and illegal are decoded from registered state only; no combinational path from res_* inputs.
- wr_addr and wr_data hold their last values when wr_en = 0; wr_en is the only qualifier.
- res_data upper word is ignored for SHORT ops.

## Timing
- Reset (clr low, asynchronous): state = IDLE; ZLo, ZHi, lo_out, hi_out, wr_addr, wr_data = 0; wr_en, done, illegal = 0; res_ready = 0 while clr is low.
- SHORT latency: accept at edge N → wr_en/done high for cycle N..N+1. Register file commits at edge N+1. Throughput is one SHORT op per cycle.
- LONG latency: accept at edge N → LO cycle N..N+1, with lo_out updated at edge N+1 → HI cycle N+1..N+2, with hi_out updated at edge N+2 and done high in that cycle. Throughput is one LONG op per 2 cycles. A new op may be accepted at edge N+2.
- ILLEGAL: illegal/done high for cycle N..N+1; the next op may be accepted at edge N+1.
- res_valid held with res_ready low (LO state): no accept. Inputs must be held by the upstream until ready.
- Simultaneous final cycle and accept: the current transaction's outputs are presented unchanged, the new op's capture takes effect at the same edge, and the next state is chosen by the new op.
- Reset mid-transaction: abandoned immediately. No further writes; lo_out and hi_out are cleared even if LO has already completed.

## Test plan
- Reset then SHORT: clr low 3 cycles → all outputs 0, res_ready 0. Release, send opcode 5'b00001, rd=5, C=64'h0000_0000_0000_0007 → next cycle wr_en=1, wr_addr=5, wr_data=32'h7, done=1.
- Back-to-back SHORT: 4 consecutive accepts (opcodes 01010, 01011, 01101, 00101; rd 1..4) → wr_en high 4 consecutive cycles with matching addr/data; res_ready never drops.
- LONG: mul, C=64'h0000_0001_FFFF_FFFE → lo_out=32'hFFFF_FFFE one cycle after accept, hi_out=32'h0000_0001 the cycle after. wr_en stays 0. res_ready low exactly one cycle.
- rd=0 and illegal: opcode 00001 rd=0 → done=1, wr_en=0. Opcode 10010 → illegal=1, done=1, no write, lo_out/hi_out unchanged.
- Stall: div accepted, res_valid held with a SHORT op during LO → accepted only at the HI edge; its write appears one cycle after hi_out updates.
- Reset mid-LONG: clr asserted during HI cycle → hi_out and lo_out = 0 immediately, done not pulsed, state IDLE after release.
